rx_reset_sm: RTL and testbench
==============================

// Module: rx_reset_sm
// PURPOSE
// - Per-channel RX reset sequencer for the ECP3 SGMII PCS, on the same refclkdiv2 domain as the TX quad reset sequencer.
// - Sits directly downstream of that TX sequencer and does not start RX bring-up until the channel's TX lane reset is released.
// - Drives the RX SERDES and RX PCS resets through a timed sequence gated by CDR lock and loss of signal (LOS).
// - Re-runs the sequence on any loss of lock or signal.
// PARAMETERS
// TIMER1_BIT  2   RX SERDES reset pulse length: timer1 done when counter1[TIMER1_BIT]=1 (2^2=4 cycles, >=20 ns at 312 MHz/2)
// TIMER2_BIT  16  CDR settle window: timer2 done when counter2[TIMER2_BIT]=1 (65536 cycles, >=400k UI worst case); bench uses 4
// PORTS
// refclkdiv2          in   1  reference clock / 2; only clock
// rst_n               in   1  asynchronous active-low reset
// tx_pcs_rst_ch_c     in   1  this channel's TX lane reset from the TX sequencer; 1 = TX not ready
// rx_cdr_lol_ch_s     in   1  CDR loss of lock, already synchronised; 1 = unlocked
// rx_los_low_ch_s     in   1  loss of signal, already synchronised; 1 = no signal
// rx_serdes_rst_ch_c  out  1  RX SERDES reset, active high
// rx_pcs_rst_ch_c     out  1  RX PCS lane reset, active high
// rx_ready            out  1  1 while the state is NORMAL (registered)
// relock_cnt          out  8  count of NORMAL->WAIT_TX exits; saturates at 8'hFF
// BEHAVIOUR
// - Reset (rst_n=0, async) values:
//   - rx_serdes_rst_ch_c=0, rx_pcs_rst_ch_c=1, rx_ready=0, relock_cnt=0, state=WAIT_TX.
//   - Registered input copies tx_int=1, lol_int=1, los_int=1.
//   - Both timers cleared.
// - Pipeline: each input is registered once (*_int). State register cs <= ns. All outputs are registered from f(cs).
//   - An input sampled at edge E gives cs updated at E+1 and outputs updated at E+2.
// - Timers clear synchronously while cs is their clear state; no async reset is derived from logic.
//   - After clearing, the counter increments each cycle and stops once bit[N]=1.
//   - The WAIT state therefore lasts 2^N+1 cycles (timer1: 5 cycles at default).
// - State outputs (serdes_rst / pcs_rst):
//   - WAIT_TX (0/1): if !tx_int & !lol_int & !los_int -> SERDES_RST; else stay.
//   - SERDES_RST (1/1): clear timer1 -> WAIT_T1.
//   - WAIT_T1 (1/1): timer1 done -> CHECK_LOL; else stay.
//   - CHECK_LOL (0/1): clear timer2 -> WAIT_T2.
//   - WAIT_T2 (0/1): lol_int|los_int|tx_int -> WAIT_TX; else timer2 done -> NORMAL; else stay.
//   - NORMAL (0/0, rx_ready=1): lol_int|los_int|tx_int -> WAIT_TX and relock_cnt+1 unless it is at FF.
//   - Undefined cs encoding: outputs 0/1, ns=WAIT_TX.
// - Simultaneous events:
//   - In WAIT_T2, a fault in the same cycle as timer done takes priority: go to WAIT_TX, not NORMAL.
//   - LOS and LOL together count as a single relock.
// - LOL/LOS is ignored during SERDES_RST, WAIT_T1 and CHECK_LOL, because the CDR is invalid while the SERDES is held in reset.
//   It is re-checked in WAIT_T2.
// - tx_pcs_rst_ch_c rising in any state other than WAIT_TX: the block takes the same path as a fault, returning to WAIT_TX from WAIT_T2 or NORMAL.
// - rst_n asserted mid-sequence: all outputs return to their reset values immediately, asynchronously. The relock count is lost.
// - rx_pcs_rst_ch_c is never 0 while rx_serdes_rst_ch_c is 1.
// TESTING (TIMER1_BIT=2, TIMER2_BIT=4)
// - Bring-up: after reset, hold tx_pcs_rst=1 with lol=los=0 -> outputs stay 0/1 indefinitely.
//   Then drop tx_pcs_rst -> serdes_rst high for exactly 6 cycles, then pcs_rst low and rx_ready=1 after 18 more cycles.
// - Settle abort: lol=1 during WAIT_T2 -> pcs_rst stays 1, rx_ready stays 0, the sequence restarts once lol=0, relock_cnt stays 0.
// - Link drop: los=1 for one cycle in NORMAL -> rx_pcs_rst_ch_c=1 two edges after the sample, relock_cnt=1, full re-sequence follows.
// - Saturation: 300 LOS pulses, each given after rx_ready -> relock_cnt=8'hFF and no wrap.
// - Priority: lol=1 in the cycle timer2 completes -> next state WAIT_TX, rx_ready never pulses.
// - Async reset: assert rst_n=0 mid-WAIT_T1 -> outputs 0/1/0/0 with no clock edge; release -> block waits in WAIT_TX.

Source files
------------

// File: rtl/rx_reset_sm.sv
// rx_reset_sm: per-channel RX reset sequencer, gated by TX lane reset, CDR lock and LOS
module rx_reset_sm #(
  parameter int TIMER1_BIT = 2,
  parameter int TIMER2_BIT = 16
) (
  input  logic       refclkdiv2,
  input  logic       rst_n,
  input  logic       tx_pcs_rst_ch_c,
  input  logic       rx_cdr_lol_ch_s,
  input  logic       rx_los_low_ch_s,
  output logic       rx_serdes_rst_ch_c,
  output logic       rx_pcs_rst_ch_c,
  output logic       rx_ready,
  output logic [7:0] relock_cnt
);
  typedef enum logic [2:0] {WAIT_TX, SERDES_RST, WAIT_T1, CHECK_LOL, WAIT_T2, NORMAL} state_t;
  state_t cs, ns;
  logic tx_int, lol_int, los_int;
  logic [TIMER1_BIT:0] counter1;
  logic [TIMER2_BIT:0] counter2;
  logic fault, t1_done, t2_done, serdes_d, pcs_d, relock;
  assign fault   = tx_int | lol_int | los_int;
  assign t1_done = counter1[TIMER1_BIT];
  assign t2_done = counter2[TIMER2_BIT];
  always_comb begin
    ns       = cs;
    serdes_d = 1'b0;
    pcs_d    = 1'b1;
    relock   = 1'b0;
    case (cs)
      WAIT_TX:    ns = fault ? WAIT_TX : SERDES_RST;
      SERDES_RST: begin
        serdes_d = 1'b1;
        ns       = WAIT_T1;
      end
      WAIT_T1:    begin
        serdes_d = 1'b1;
        ns       = t1_done ? CHECK_LOL : WAIT_T1;
      end
      CHECK_LOL:  ns = WAIT_T2;
      // a fault outranks a timer that expires in the same cycle
      WAIT_T2:    ns = fault ? WAIT_TX : t2_done ? NORMAL : WAIT_T2;
      NORMAL:     begin
        pcs_d  = 1'b0;
        relock = fault;
        ns     = fault ? WAIT_TX : NORMAL;
      end
      default:    ns = WAIT_TX;
    endcase
  end
  always_ff @(posedge refclkdiv2 or negedge rst_n) begin
    if (!rst_n) begin
      tx_int             <= 1'b1;
      lol_int            <= 1'b1;
      los_int            <= 1'b1;
      cs                 <= WAIT_TX;
      counter1           <= '0;
      counter2           <= '0;
      rx_serdes_rst_ch_c <= 1'b0;
      rx_pcs_rst_ch_c    <= 1'b1;
      rx_ready           <= 1'b0;
      relock_cnt         <= 8'h00;
    end else begin
      tx_int             <= tx_pcs_rst_ch_c;
      lol_int            <= rx_cdr_lol_ch_s;
      los_int            <= rx_los_low_ch_s;
      cs                 <= ns;
      counter1           <= (cs == SERDES_RST) ? '0 : counter1 + {{TIMER1_BIT{1'b0}}, ~t1_done};
      counter2           <= (cs == CHECK_LOL) ? '0 : counter2 + {{TIMER2_BIT{1'b0}}, ~t2_done};
      rx_serdes_rst_ch_c <= serdes_d;
      rx_pcs_rst_ch_c    <= pcs_d;
      rx_ready           <= (cs == NORMAL);
      relock_cnt         <= (relock && relock_cnt != 8'hFF) ? relock_cnt + 8'h01 : relock_cnt;
    end
  end
endmodule

// File: tb/tb_rx_reset_sm.sv
// tb_rx_reset_sm: vector table, hand sequences and random traffic against a step-count model
module tb_rx_reset_sm;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx = 1'b1, lol = 1'b0, los = 1'b0;
  logic serdes, pcs, ready;
  logic [7:0] cnt;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  rx_reset_sm #(.TIMER1_BIT(2), .TIMER2_BIT(4)) dut (
    .refclkdiv2(clk), .rst_n(rst_n), .tx_pcs_rst_ch_c(tx), .rx_cdr_lol_ch_s(lol),
    .rx_los_low_ch_s(los), .rx_serdes_rst_ch_c(serdes), .rx_pcs_rst_ch_c(pcs),
    .rx_ready(ready), .relock_cnt(cnt)
  );

  // Model: s = cycles since bring-up began (-1 idle); 0..5 SERDES reset, 6 check, 7..23 settle, 24 up
  int s;
  logic [7:0] mc;
  logic mtx, mlol, mlos, ms, mp, mr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s <= -1; mc <= 8'h00; mtx <= 1'b1; mlol <= 1'b1; mlos <= 1'b1;
      ms <= 1'b0; mp <= 1'b1; mr <= 1'b0;
    end else begin
      mtx <= tx; mlol <= lol; mlos <= los;
      ms <= (s >= 0 && s <= 5);
      mp <= (s < 24);
      mr <= (s >= 24);
      if (s < 0) begin
        if (!mtx && !mlol && !mlos) s <= 0;
      end else if (s >= 7 && (mtx || mlol || mlos)) begin
        s <= -1;
        if (s >= 24 && mc != 8'hFF) mc <= mc + 8'h01;
      end else if (s < 24) s <= s + 1;
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_serdes", {7'd0, serdes}, {7'd0, ms});
    chk("model_pcs", {7'd0, pcs}, {7'd0, mp});
    chk("model_ready", {7'd0, ready}, {7'd0, mr});
    chk("model_cnt", cnt, mc);
    chk("pcs_covers_serdes", {7'd0, serdes & ~pcs}, 8'd0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tx = 1'b1; lol = 1'b0; los = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_ready(input int bound);
    int i;
    for (i = 0; i < bound && ready !== 1'b1; i++) cyc(1);
    if (ready !== 1'b1) begin
      checks++; errors++;
      $display("FAIL wait_ready: ready=%b after %0d cycles, expected 1", ready, bound);
    end
  endtask

  typedef struct {
    logic tx, lol, los;
    int n;
    logic s, p, r;
    logic [7:0] c;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int t_rise, t_fall, t_rdy;
    tbl[0]  = '{1, 0, 0, 30, 0, 1, 0, 8'd0};
    tbl[1]  = '{0, 0, 0, 40, 0, 0, 1, 8'd0};
    tbl[2]  = '{0, 0, 1, 3,  0, 1, 0, 8'd1};
    tbl[3]  = '{0, 0, 0, 40, 0, 0, 1, 8'd1};
    tbl[4]  = '{0, 1, 1, 3,  0, 1, 0, 8'd2};
    tbl[5]  = '{0, 1, 0, 50, 0, 1, 0, 8'd2};
    tbl[6]  = '{0, 0, 0, 3,  1, 1, 0, 8'd2};
    tbl[7]  = '{0, 1, 0, 4,  1, 1, 0, 8'd2};
    tbl[8]  = '{0, 1, 0, 10, 0, 1, 0, 8'd2};
    tbl[9]  = '{1, 0, 0, 10, 0, 1, 0, 8'd2};
    tbl[10] = '{0, 0, 0, 30, 0, 0, 1, 8'd2};
    tbl[11] = '{1, 0, 0, 3,  0, 1, 0, 8'd3};

    do_reset();
    chk("reset_serdes", {7'd0, serdes}, 8'd0);
    chk("reset_pcs", {7'd0, pcs}, 8'd1);
    chk("reset_ready", {7'd0, ready}, 8'd0);
    chk("reset_cnt", cnt, 8'd0);
    for (int i = 0; i < 12; i++) begin
      tx = tbl[i].tx; lol = tbl[i].lol; los = tbl[i].los;
      cyc(tbl[i].n);
      chk($sformatf("vec%0d_serdes", i), {7'd0, serdes}, {7'd0, tbl[i].s});
      chk($sformatf("vec%0d_pcs", i), {7'd0, pcs}, {7'd0, tbl[i].p});
      chk($sformatf("vec%0d_ready", i), {7'd0, ready}, {7'd0, tbl[i].r});
      chk($sformatf("vec%0d_cnt", i), cnt, tbl[i].c);
    end

    // exact bring-up timing
    do_reset();
    cyc(10);
    tx = 1'b0;
    t_rise = -1; t_fall = -1; t_rdy = -1;
    for (int i = 0; i < 60; i++) begin
      cyc(1);
      if (serdes && t_rise < 0) t_rise = i;
      if (!serdes && t_rise >= 0 && t_fall < 0) t_fall = i;
      if (ready && t_rdy < 0) t_rdy = i;
    end
    chk("serdes_pulse_len", 8'(t_fall - t_rise), 8'd6);
    chk("fall_to_ready", 8'(t_rdy - t_fall), 8'd18);

    // lol arrives in the cycle the settle timer completes
    do_reset();
    cyc(3);
    tx = 1'b0;
    cyc(24);
    lol = 1'b1;
    cyc(1);
    lol = 1'b0;
    t_rdy = 0;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      if (ready) t_rdy = 1;
    end
    chk("priority_no_ready", 8'(t_rdy), 8'd0);
    chk("priority_cnt", cnt, 8'd0);
    wait_ready(40);

    // async reset mid WAIT_T1
    do_reset();
    tx = 1'b0;
    cyc(4);
    #2 rst_n = 1'b0;
    #1;
    chk("async_serdes", {7'd0, serdes}, 8'd0);
    chk("async_pcs", {7'd0, pcs}, 8'd1);
    chk("async_ready", {7'd0, ready}, 8'd0);
    chk("async_cnt", cnt, 8'd0);
    @(negedge clk);
    rst_n = 1'b1; tx = 1'b1;
    cyc(20);
    chk("after_async_pcs", {7'd0, pcs}, 8'd1);
    chk("after_async_serdes", {7'd0, serdes}, 8'd0);

    // random traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      tx  = ($urandom_range(0, 99) < 1);
      lol = ($urandom_range(0, 99) < 1);
      los = ($urandom_range(0, 99) < 1);
      cyc(1);
    end

    // saturation
    do_reset();
    tx = 1'b0; lol = 1'b0; los = 1'b0;
    for (int i = 0; i < 300; i++) begin
      wait_ready(100);
      los = 1'b1;
      cyc(1);
      los = 1'b0;
      cyc(3);
    end
    chk("saturated_cnt", cnt, 8'hFF);
    wait_ready(100);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
